life_cell: RTL and testbench
============================

LIFE_CELL -- requirements
Module: life_cell

Interface
REQ-001 SHALL have one clock, clk; reset is asynchronous and active-low, port reset_n.
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk        in   1  single clock, all state updates on rising edge
  reset_n    in   1  asynchronous active-low reset
  two_ln     in   1  exactly-two-live-neighbours flag from upstream detector
  three_ln   in   1  exactly-three-live-neighbours flag from upstream detector
  load       in   1  seed-load strobe
  seed       in   1  cell value written on load
  step_req   in   1  request to advance one generation (level, held until step_ack)
  step_ack   out  1  one-cycle pulse, generation committed
  alive      out  1  current cell state
  changed    out  1  alive differs from previous generation (valid after commit)
  stable     out  1  no change for 15 consecutive generations
  err        out  1  sticky: two_ln and three_ln both high when sampled
  age        out  8  generations survived (present only with LIFE_CELL_AGE_EN)

Function
REQ-003 SHALL implement FSM states IDLE, SAMPLE, COMMIT, WAIT_DROP.
REQ-004 IDLE -> SAMPLE on rising clk with step_req=1 and load=0.
REQ-005 SAMPLE: SHALL register two_ln, three_ln; -> COMMIT next cycle.
REQ-006 COMMIT: SHALL update alive_next = three_ln_r | (alive & two_ln_r); SHALL pulse step_ack for exactly this one cycle; -> WAIT_DROP.
REQ-007 WAIT_DROP -> IDLE when step_req=0; SHALL not start a new generation until step_req has been seen low.
REQ-008 Latency: step_req rise to alive update and step_ack = 2 cycles (edge N samples, edge N+1 commits, alive valid after edge N+1).
REQ-009 changed SHALL be set at commit to (alive_next != alive), held until next commit or load.
REQ-010 Stable counter: 4-bit; at commit SHALL increment (saturating at 15) when unchanged, clear to 0 when changed; stable = (count == 15).
REQ-011 err SHALL set when two_ln_r and three_ln_r both 1 in COMMIT; SHALL then apply three_ln priority (cell alive); err cleared only by reset.
REQ-012 load SHALL have priority over any state: alive <= seed, changed <= 0, stable count <= 0, FSM -> IDLE, no step_ack issued.
REQ-013 load during SAMPLE or COMMIT SHALL abort the generation; step_ack SHALL NOT pulse; if step_req still high, FSM enters IDLE and restarts on next edge only after load=0.
REQ-014 Simultaneous load and step_req in IDLE: load wins, step starts the following cycle if step_req held.
REQ-015 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-016 reset_n=0 SHALL asynchronously force: FSM IDLE, alive 0, changed 0, stable count 0, stable 0, err 0, step_ack 0, age 0.
REQ-017 Reset mid-generation SHALL discard sampled flags; after release FSM begins in IDLE and requires step_req sampled high.
REQ-018 Reset release SHALL be synchronous-deassert safe: first state change no earlier than first rising clk after reset_n=1.

Configuration
REQ-019 Macro LIFE_CELL_AGE_EN defined: age port present; at commit age SHALL increment (saturating 255) if alive_next and alive both 1, load 0 if alive_next=0; load sets age 0.
REQ-020 LIFE_CELL_AGE_EN undefined: age port and counter absent; all other behaviour identical.

Verification
REQ-021 Reset, load seed=0, two_ln=0 three_ln=1, step_req=1 -> step_ack 2 cycles later, alive=1, changed=1.
REQ-022 alive=1, two_ln=1 three_ln=0, step -> alive=1, changed=0; alive=0 same flags -> alive stays 0.
REQ-023 alive=1, flags 0/0, step -> alive=0, changed=1; 15 further idle-flag steps -> stable=1 on 15th commit.
REQ-024 two_ln=1 three_ln=1, step -> err=1, alive=1; err remains 1 after subsequent load; cleared by reset_n=0.
REQ-025 step_req high, load asserted in SAMPLE cycle -> no step_ack, alive=seed, FSM IDLE; step_req held -> generation restarts after load drops.
REQ-026 LIFE_CELL_AGE_EN: alive cell, two_ln=1 held, 300 steps -> age saturates at 255; reset_n=0 mid-SAMPLE -> all outputs 0 immediately.

Source files
------------

// File: rtl/life_cell.sv
// Single Game-of-Life cell: seed load, handshaked generation stepping, change/stability tracking.
// Optional LIFE_CELL_AGE_EN adds an 8-bit saturating survival-age counter on port age.
module life_cell (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       two_ln,
  input  logic       three_ln,
  input  logic       load,
  input  logic       seed,
  input  logic       step_req,
  output logic       step_ack,
  output logic       alive,
  output logic       changed,
  output logic       stable,
  output logic       err
`ifdef LIFE_CELL_AGE_EN
  ,
  output logic [7:0] age
`endif
);

  typedef enum logic [1:0] {IDLE, SAMPLE, COMMIT, WAIT_DROP} state_t;

  state_t     state, state_nxt;
  logic       two_ln_r, three_ln_r;
  logic [3:0] stable_cnt;
  logic       alive_next;
  logic       commit;

  // Three neighbours always wins, so a contradictory flag pair still yields a live cell.
  assign alive_next = three_ln_r | (alive & two_ln_r);
  assign commit     = (state == SAMPLE) && !load;
  assign stable     = (stable_cnt == 4'hF);

  // NOTE: every combinational output gets a default before the case, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (step_req) state_nxt = SAMPLE;
      SAMPLE:    state_nxt = COMMIT;
      COMMIT:    state_nxt = WAIT_DROP;
      WAIT_DROP: if (!step_req) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (load) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      two_ln_r   <= 1'b0;
      three_ln_r <= 1'b0;
    end else if (state == IDLE && step_req && !load) begin
      two_ln_r   <= two_ln;
      three_ln_r <= three_ln;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alive      <= 1'b0;
      changed    <= 1'b0;
      stable_cnt <= 4'd0;
      step_ack   <= 1'b0;
    end else if (load) begin
      alive      <= seed;
      changed    <= 1'b0;
      stable_cnt <= 4'd0;
      step_ack   <= 1'b0;
    end else begin
      step_ack <= commit;
      if (commit) begin
        alive   <= alive_next;
        changed <= (alive_next != alive);
        if (alive_next != alive)     stable_cnt <= 4'd0;
        else if (stable_cnt != 4'hF) stable_cnt <= stable_cnt + 4'd1;
      end
    end
  end

  // err is deliberately untouched by load; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            err <= 1'b0;
    else if (commit && two_ln_r && three_ln_r) err <= 1'b1;
  end

`ifdef LIFE_CELL_AGE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   age <= 8'd0;
    else if (load)  age <= 8'd0;
    else if (commit) begin
      if (!alive_next)                  age <= 8'd0;
      else if (alive && age != 8'hFF)   age <= age + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_life_cell.sv
// Scoreboard bench for life_cell: stimulus pushes expected commit results, a monitor pops on step_ack.
// Age checks are compiled in when LIFE_CELL_AGE_EN is defined.
module tb_life_cell;

  logic clk = 1'b0;
  logic reset_n, two_ln, three_ln, load, seed, step_req;
  logic step_ack, alive, changed, stable, err;
`ifdef LIFE_CELL_AGE_EN
  logic [7:0] age;
`endif

  always #5 clk = ~clk;

  life_cell dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .two_ln   (two_ln),
    .three_ln (three_ln),
    .load     (load),
    .seed     (seed),
    .step_req (step_req),
    .step_ack (step_ack),
    .alive    (alive),
    .changed  (changed),
    .stable   (stable),
    .err      (err)
`ifdef LIFE_CELL_AGE_EN
    ,
    .age      (age)
`endif
  );

  typedef struct packed {
    logic       alive;
    logic       changed;
    logic       stable;
    logic       err;
`ifdef LIFE_CELL_AGE_EN
    logic [7:0] age;
`endif
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic m_alive, m_changed, m_err;
  int   m_cnt;
`ifdef LIFE_CELL_AGE_EN
  int   m_age;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_alive = 1'b0; m_changed = 1'b0; m_err = 1'b0; m_cnt = 0;
`ifdef LIFE_CELL_AGE_EN
    m_age = 0;
`endif
  endfunction

  function automatic void model_load(input logic s);
    m_alive = s; m_changed = 1'b0; m_cnt = 0;
`ifdef LIFE_CELL_AGE_EN
    m_age = 0;
`endif
  endfunction

  // Reference rule written from the cell definition, then queued for the monitor.
  function automatic void model_step(input logic t, input logic th);
    logic nxt;
    exp_t e;
    nxt = th | (m_alive & t);
    if (t && th) m_err = 1'b1;
    m_changed = (nxt != m_alive);
    if (m_changed)      m_cnt = 0;
    else if (m_cnt < 15) m_cnt = m_cnt + 1;
`ifdef LIFE_CELL_AGE_EN
    if (!nxt)                         m_age = 0;
    else if (m_alive && m_age < 255)  m_age = m_age + 1;
    e.age = m_age[7:0];
`endif
    m_alive   = nxt;
    e.alive   = m_alive;
    e.changed = m_changed;
    e.stable  = (m_cnt == 15);
    e.err     = m_err;
    exp_q.push_back(e);
  endfunction

  // Monitor: every step_ack must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && step_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got step_ack=1 expected no ack at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("ack_alive",   alive,   e.alive);
          check("ack_changed", changed, e.changed);
          check("ack_stable",  stable,  e.stable);
          check("ack_err",     err,     e.err);
`ifdef LIFE_CELL_AGE_EN
          check("ack_age",     age,     e.age);
`endif
        end
      end
    end
  end

  // Entered just after a negedge with step_req high; waits (bounded) for the ack, then drops the request.
  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (step_ack !== 1'b1 && n < 10);
    if (step_ack !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: got no step_ack expected one within 10 cycles at %0t", $time);
    end else begin
      check("ack_latency", n, 2);
    end
    @(negedge clk);
    check("ack_one_cycle", step_ack, 1'b0);
    @(negedge clk);
    step_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_step(input logic t, input logic th);
    two_ln = t; three_ln = th; step_req = 1'b1;
    model_step(t, th);
    wait_ack();
  endtask

  task automatic do_load(input logic s);
    load = 1'b1; seed = s;
    @(negedge clk);
    load = 1'b0;
    model_load(s);
    check("load_alive",   alive,   m_alive);
    check("load_changed", changed, 1'b0);
    check("load_stable",  stable,  1'b0);
  endtask

  initial begin
    reset_n = 1'b0; two_ln = 1'b0; three_ln = 1'b0;
    load = 1'b0; seed = 1'b0; step_req = 1'b0;
    model_reset();
    #1;
    check("rst_alive",    alive,    1'b0);
    check("rst_changed",  changed,  1'b0);
    check("rst_stable",   stable,   1'b0);
    check("rst_err",      err,      1'b0);
    check("rst_step_ack", step_ack, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Birth, survival, and a dead cell staying dead on two neighbours.
    do_load(1'b0);
    do_step(1'b0, 1'b1);
    do_step(1'b1, 1'b0);
    do_load(1'b0);
    do_step(1'b1, 1'b0);

    // Death, then fifteen unchanged generations reach stable.
    do_load(1'b1);
    do_step(1'b0, 1'b0);
    for (int i = 0; i < 15; i++) do_step(1'b0, 1'b0);
    check("stable_after_15", stable, 1'b1);
    do_step(1'b0, 1'b0);

    // Contradictory flags: sticky err, three-neighbour priority, survives load.
    do_step(1'b1, 1'b1);
    do_load(1'b0);
    check("err_after_load", err, 1'b1);

    // Load during SAMPLE aborts; held step_req restarts after load drops.
    two_ln = 1'b0; three_ln = 1'b1; step_req = 1'b1;
    @(negedge clk);
    load = 1'b1; seed = 1'b1;
    @(negedge clk);
    check("abort_no_ack",  step_ack, 1'b0);
    check("abort_alive",   alive,    1'b1);
    check("abort_changed", changed,  1'b0);
    model_load(1'b1);
    load = 1'b0; two_ln = 1'b0; three_ln = 1'b0;
    model_step(1'b0, 1'b0);
    wait_ack();

    // Load and step_req together in IDLE: load first, step on the following cycle.
    two_ln = 1'b0; three_ln = 1'b1; step_req = 1'b1; load = 1'b1; seed = 1'b0;
    @(negedge clk);
    check("both_no_ack", step_ack, 1'b0);
    check("both_alive",  alive,    1'b0);
    model_load(1'b0);
    load = 1'b0;
    model_step(1'b0, 1'b1);
    wait_ack();

`ifdef LIFE_CELL_AGE_EN
    do_load(1'b1);
    check("age_after_load", age, 8'd0);
    for (int i = 0; i < 300; i++) do_step(1'b1, 1'b0);
    check("age_saturated", age, 8'd255);
`endif

    // Reset in the middle of SAMPLE clears everything immediately.
    two_ln = 1'b0; three_ln = 1'b1; step_req = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    check("midrst_alive",    alive,    1'b0);
    check("midrst_changed",  changed,  1'b0);
    check("midrst_stable",   stable,   1'b0);
    check("midrst_err",      err,      1'b0);
    check("midrst_step_ack", step_ack, 1'b0);
`ifdef LIFE_CELL_AGE_EN
    check("midrst_age",      age,      8'd0);
`endif
    step_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle_ack", step_ack, 1'b0);
    check("post_rst_alive",    alive,    1'b0);

    do_step(1'b0, 1'b1);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
